// File: rtl/alu_ctrl_pkg.sv
// Shared state encoding, default widths and opcode-pointer wrap helper for the ALU op sequencer.
package alu_ctrl_pkg;

   localparam int NUM_WIDTH_DEF = 8;
   localparam int OP_WIDTH_DEF  = 4;
   localparam int NUM_OPS_DEF   = 10;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE
   } seq_state_t;

   // Next opcode pointer; a single-opcode configuration stays at 0.
   function automatic int wrap_inc(input int ptr, input int limit);
      return (ptr >= limit - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter, rising-edge detect; press is registered.
// Press appears a few cycles after the raw edge once the level has held; release and short glitches produce nothing.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic sync_1;
   logic sync_2;
   logic sync_prev;
   logic level;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         sync_prev  <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync_1    <= raw;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
         press     <= 1'b0;
         // Any change restarts the stability window; the level moves only after a full run of equal samples.
         if (sync_2 != sync_prev) begin
            stable_cnt <= '0;
         end else if (stable_cnt != CNT_LAST) begin
            stable_cnt <= stable_cnt + 1'b1;
         end else begin
            level <= sync_2;
            press <= sync_2 & ~level;
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU issue controller: press -> ISSUE (alu_start) -> WAIT -> CAPTURE (answer_valid); ALU_SEQ_AUTO_STEP_EN adds a periodic press.
// Press to answer_valid takes RESULT_LATENCY+2 cycles; presses while busy queue one deep and further ones are dropped.
module alu_op_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int NUM_WIDTH       = NUM_WIDTH_DEF,
   parameter int OP_WIDTH        = OP_WIDTH_DEF,
   parameter int NUM_OPS         = NUM_OPS_DEF,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int RESULT_LATENCY  = 1,
   parameter int AUTO_PERIOD     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 button,
   input  logic [NUM_WIDTH-1:0] number_1,
   input  logic [NUM_WIDTH-1:0] number_2,
   input  logic [NUM_WIDTH:0]   alu_result,
   output logic [NUM_WIDTH-1:0] alu_number_1,
   output logic [NUM_WIDTH-1:0] alu_number_2,
   output logic [OP_WIDTH-1:0]  alu_op,
   output logic                 alu_start,
   output logic [NUM_WIDTH:0]   answer,
   output logic                 answer_valid,
   output logic                 busy
);

   localparam int WW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

   logic btn_press;
   logic auto_press;
   logic go;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (button),
      .press(btn_press)
   );

`ifdef ALU_SEQ_AUTO_STEP_EN
   localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   logic [AW-1:0] auto_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         auto_cnt   <= '0;
         auto_press <= 1'b0;
      end else begin
         auto_press <= 1'b0;
         if (auto_cnt == AW'(AUTO_PERIOD - 1)) begin
            auto_cnt   <= '0;
            auto_press <= 1'b1;
         end else begin
            auto_cnt <= auto_cnt + 1'b1;
         end
      end
   end
`else
   assign auto_press = (AUTO_PERIOD < 1);
`endif

   assign go = btn_press | auto_press;

   seq_state_t          state;
   logic [OP_WIDTH-1:0] op_ptr;
   logic                pending;
   logic [WW-1:0]       wait_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         op_ptr       <= '0;
         pending      <= 1'b0;
         wait_cnt     <= '0;
         alu_number_1 <= '0;
         alu_number_2 <= '0;
         alu_op       <= '0;
         alu_start    <= 1'b0;
         answer       <= '0;
         answer_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         alu_start    <= 1'b0;
         answer_valid <= 1'b0;
         if (state != IDLE && go) begin
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (go || pending) begin
                  state        <= ISSUE;
                  busy         <= 1'b1;
                  alu_number_1 <= number_1;
                  alu_number_2 <= number_2;
                  alu_op       <= op_ptr;
                  alu_start    <= 1'b1;
                  // When the queued press is consumed, a coincident new press takes its place.
                  pending      <= pending & go;
               end
            end
            ISSUE: begin
               wait_cnt <= WW'(RESULT_LATENCY - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  answer       <= alu_result;
                  answer_valid <= 1'b1;
                  op_ptr       <= OP_WIDTH'(wrap_inc(int'(op_ptr), NUM_OPS));
                  state        <= CAPTURE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            CAPTURE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench: two sequencer instances (fast debounce/latency 1, and latency 8) against a transaction-level model.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] button;
   logic [7:0] number_1;
   logic [7:0] number_2;
   logic [8:0] alu_res [2];
   logic [7:0] a_n1 [2];
   logic [7:0] a_n2 [2];
   logic [3:0] a_op [2];
   logic       a_start [2];
   logic [8:0] ans [2];
   logic       ans_vld [2];
   logic       busy_w [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit churn = 1'b0;

   // Transaction-level model state per instance.
   int         exp_op [2];
   bit         inflight [2];
   logic [7:0] exp_a [2];
   logic [7:0] exp_b [2];
   logic [8:0] exp_r [2];
   int         start_cyc [2];
   int         last_valid_cyc [2];
   int         gap [2];
   int         start_cnt [2];
   int         valid_cnt [2];
   logic [8:0] last_ans [2];
   int         last_op [2];
   bit         prev_start [2];
   logic [7:0] n1_prev;
   logic [7:0] n2_prev;
   int         cd [2];

   always #5 clk = ~clk;

   alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .RESULT_LATENCY(1)) u_fast (
      .clk(clk), .reset(reset), .button(button[0]),
      .number_1(number_1), .number_2(number_2), .alu_result(alu_res[0]),
      .alu_number_1(a_n1[0]), .alu_number_2(a_n2[0]), .alu_op(a_op[0]),
      .alu_start(a_start[0]), .answer(ans[0]), .answer_valid(ans_vld[0]), .busy(busy_w[0])
   );

   alu_op_sequencer #(.DEBOUNCE_CYCLES(1), .RESULT_LATENCY(8)) u_slow (
      .clk(clk), .reset(reset), .button(button[1]),
      .number_1(number_1), .number_2(number_2), .alu_result(alu_res[1]),
      .alu_number_1(a_n1[1]), .alu_number_2(a_n2[1]), .alu_op(a_op[1]),
      .alu_start(a_start[1]), .answer(ans[1]), .answer_valid(ans_vld[1]), .busy(busy_w[1])
   );

   function automatic logic [8:0] alu_fn(input int op, input logic [7:0] a, input logic [7:0] b);
      case (op % 4)
         0:       return {1'b0, a} + {1'b0, b};
         1:       return {1'b0, a} - {1'b0, b};
         2:       return {1'b0, a & b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 8;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int idx, input int hi, input int lo);
      button[idx] = 1'b1;
      step(hi);
      button[idx] = 1'b0;
      step(lo);
   endtask

   task automatic wait_idle(input int idx);
      int t = 0;
      int quiet = 0;
      step(12);
      while (quiet < 3 && t < 300) begin
         if (busy_w[idx]) quiet = 0;
         else quiet++;
         step(1);
         t++;
      end
      check_eq("idle_timeout", quiet, 3);
   endtask

   task automatic check_reset_outputs(input int i);
      check_eq("rst_alu_start", a_start[i], 0);
      check_eq("rst_answer_valid", ans_vld[i], 0);
      check_eq("rst_busy", busy_w[i], 0);
      check_eq("rst_alu_op", a_op[i], 0);
      check_eq("rst_operands", {a_n1[i], a_n2[i]}, 0);
      check_eq("rst_answer", ans[i], 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (churn) begin
            number_1 = 8'($urandom);
            number_2 = 8'($urandom);
         end
      end
   end

   // External ALU: result is only valid exactly RESULT_LATENCY cycles after alu_start, junk otherwise.
   initial begin
      cd[0] = 0;
      cd[1] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            alu_res[i] = 9'($urandom);
            if (cd[i] > 0) begin
               cd[i]--;
               if (cd[i] == 0) alu_res[i] = alu_fn(int'(a_op[i]), a_n1[i], a_n2[i]);
            end
            if (a_start[i] && reset) cd[i] = lat(i);
            if (!reset) cd[i] = 0;
         end
      end
   end

   // Scoreboard: every issue and every answer is checked against the opcode/operand model.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!reset) begin
               inflight[i]   = 1'b0;
               exp_op[i]     = 0;
               prev_start[i] = 1'b0;
            end else begin
               if (ans_vld[i]) begin
                  check_eq("answer_expected", inflight[i], 1);
                  check_eq("answer", ans[i], exp_r[i]);
                  check_eq("latency", cyc - start_cyc[i], lat(i) + 1);
                  check_eq("held_operands", {a_n1[i], a_n2[i]}, {exp_a[i], exp_b[i]});
                  inflight[i]       = 1'b0;
                  valid_cnt[i]++;
                  last_ans[i]       = ans[i];
                  last_valid_cyc[i] = cyc;
               end
               if (a_start[i]) begin
                  check_eq("start_pulse", prev_start[i], 0);
                  check_eq("start_overlap", inflight[i], 0);
                  check_eq("alu_op", a_op[i], exp_op[i]);
                  check_eq("operands", {a_n1[i], a_n2[i]}, {n1_prev, n2_prev});
                  exp_a[i]     = n1_prev;
                  exp_b[i]     = n2_prev;
                  exp_r[i]     = alu_fn(exp_op[i], n1_prev, n2_prev);
                  last_op[i]   = int'(a_op[i]);
                  exp_op[i]    = (exp_op[i] + 1) % 10;
                  inflight[i]  = 1'b1;
                  gap[i]       = cyc - last_valid_cyc[i];
                  start_cyc[i] = cyc;
                  start_cnt[i]++;
               end
               prev_start[i] = a_start[i];
            end
         end
         n1_prev = number_1;
         n2_prev = number_2;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int v0;
      int t;
      for (int i = 0; i < 2; i++) begin
         start_cnt[i]      = 0;
         valid_cnt[i]      = 0;
         last_valid_cyc[i] = 0;
         gap[i]            = 0;
         last_op[i]        = -1;
      end
      reset    = 1'b0;
      button   = 2'b11;
      number_1 = 8'($urandom);
      number_2 = 8'($urandom);

      // Reset held with the button pressed: everything stays quiet.
      step(3);
      for (int i = 0; i < 2; i++) check_reset_outputs(i);
      button = 2'b00;
      step(1);
      reset = 1'b1;
      step(5);

      // Single clean press with known operands.
      number_1 = 8'h0A;
      number_2 = 8'h02;
      s0 = start_cnt[0];
      v0 = valid_cnt[0];
      press(0, 10, 10);
      wait_idle(0);
      check_eq("single_starts", start_cnt[0] - s0, 1);
      check_eq("single_valids", valid_cnt[0] - v0, 1);
      check_eq("single_answer", last_ans[0], 9'h00C);
      check_eq("single_op", last_op[0], 0);
      number_1 = 8'($urandom);
      press(0, 8, 10);
      wait_idle(0);
      check_eq("next_op", last_op[0], 1);

      // Bounce: toggling every cycle never settles long enough.
      s0 = start_cnt[0];
      for (int k = 0; k < 8; k++) begin
         button[0] = ~button[0];
         step(1);
      end
      button[0] = 1'b0;
      step(20);
      check_eq("bounce_starts", start_cnt[0] - s0, 0);

      // Short low glitch while held high still yields a single press.
      s0 = start_cnt[0];
      button[0] = 1'b1;
      step(6);
      button[0] = 1'b0;
      step($urandom_range(1, 3));
      button[0] = 1'b1;
      step(8);
      button[0] = 1'b0;
      step(10);
      wait_idle(0);
      check_eq("glitch_starts", start_cnt[0] - s0, 1);

      // Eleven random presses with churning operands: opcode sequence wraps through 9 -> 0.
      churn = 1'b1;
      s0 = start_cnt[0];
      for (int k = 0; k < 11; k++) begin
         press(0, $urandom_range(6, 12), $urandom_range(6, 10));
         wait_idle(0);
      end
      check_eq("wrap_starts", start_cnt[0] - s0, 11);
      check_eq("wrap_valids", valid_cnt[0] - v0, 14);

      // Three presses on the slow instance: one runs, one queues, one is dropped.
      s0 = start_cnt[1];
      v0 = valid_cnt[1];
      for (int k = 0; k < 3; k++) press(1, 2, 2);
      wait_idle(1);
      check_eq("busy_starts", start_cnt[1] - s0, 2);
      check_eq("busy_valids", valid_cnt[1] - v0, 2);
      check_eq("pending_gap", gap[1], 2);

      // Reset in the middle of WAIT aborts the operation and rewinds the opcode pointer.
      v0 = valid_cnt[1];
      press(1, 2, 2);
      t = 0;
      while (!busy_w[1] && t < 50) begin
         step(1);
         t++;
      end
      check_eq("abort_busy_seen", busy_w[1], 1);
      step(3);
      reset = 1'b0;
      step(2);
      check_reset_outputs(1);
      reset = 1'b1;
      step(20);
      check_eq("abort_no_valid", valid_cnt[1] - v0, 0);
      press(1, 2, 2);
      wait_idle(1);
      check_eq("abort_next_op", last_op[1], 0);
      check_eq("abort_next_valid", valid_cnt[1] - v0, 1);
      churn = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
